vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter TICK_DIV, 4, clk cycles per pixel; legal values 2..16.
REQ-006 clk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 graph_rgb  input  12  pixel colour from the display generator, 4R:4G:4B.
REQ-009 p_tick  output  1  pixel-enable strobe, high for exactly one clk every TICK_DIV clks.
REQ-010 p_x  output  10  current pixel column, 0..H_TOTAL-1, where H_TOTAL = sum of the four H values (800).
REQ-011 p_y  output  10  current line, 0..V_TOTAL-1, where V_TOTAL = sum of the four V values (525).
REQ-012 video_on  output  1  high when p_x < H_DISPLAY and p_y < V_DISPLAY.
REQ-013 hsync, vsync  output  1 each  active-low sync pulses.
REQ-014 frame_start  output  1  one-clk pulse marking entry to (0,0).
REQ-015 vga_rgb  output  12  gated colour to the DAC pins.

Function
REQ-016 Tick divider: counter 0..TICK_DIV-1, increments every clk, wraps to 0; p_tick is registered and is high in the clk cycle after the divider holds TICK_DIV-1.
REQ-017 p_x and p_y change only in the clk cycle in which p_tick is high.
REQ-018 On each p_tick, p_x increments; at H_TOTAL-1 it wraps to 0 and p_y increments; at p_y = V_TOTAL-1 with the p_x wrap, p_y wraps to 0.
REQ-019 hsync, vsync, and video_on are registered from next-state counter values, so they change in the same clk as p_x/p_y (zero skew).
REQ-020 hsync is 0 iff H_DISPLAY+H_FRONT <= p_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
REQ-021 vsync is 0 iff V_DISPLAY+V_FRONT <= p_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
REQ-022 frame_start is high for exactly one clk, the same clk in which (p_x,p_y) becomes (0,0) from (799,524).
REQ-023 vga_rgb is updated only when p_tick is high, to graph_rgb if video_on is 1 (value before that update), else to 12'h000; latency is one pixel.
REQ-024 Outside the visible region, vga_rgb is 12'h000 regardless of graph_rgb.
REQ-025 Counter widths hold H_TOTAL-1 and V_TOTAL-1 without overflow; no value >= H_TOTAL or >= V_TOTAL ever appears on p_x or p_y.

Reset
REQ-026 While rst_n = 0 at a clk edge, the divider is 0 and outputs are: p_tick=0, p_x=0, p_y=0, hsync=1, vsync=1, video_on=1, frame_start=0, vga_rgb=12'h000.
REQ-027 Reset asserted mid-frame or mid-tick takes effect at the next clk edge and overrides any pending tick or wrap.
REQ-028 After rst_n rises, the first p_tick occurs TICK_DIV clks later, and p_x becomes 1 in that cycle.
REQ-029 No frame_start is generated on reset exit.

Verification
REQ-030 Reset release, TICK_DIV=4 -> p_tick high in clk 4, 8, 12, ... counted from the first clk with rst_n=1; p_x = 1, 2, 3 on those clks.
REQ-031 Run to p_x=799, p_y=10 -> next p_tick: p_x=0, p_y=11; hsync low for exactly 96 ticks starting at p_x=656.
REQ-032 Run full frame -> vsync low for exactly 2 lines (1600 ticks) at p_y 490..491; frame_start pulses once per 1,680,000 clks with (p_x,p_y)=(0,0).
REQ-033 Drive graph_rgb=12'hF0F constantly -> vga_rgb=12'hF0F one tick after visible pixels; 12'h000 for p_x>=640 or p_y>=480.
REQ-034 Assert rst_n=0 for 1 clk at p_x=700, p_y=300 -> next clk all outputs at reset values; normal timing resumes per REQ-028.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, raster counters, registered syncs
// and a colour gate, all aligned so outputs change together on each pixel tick.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] graph_rgb,
  output logic        p_tick,
  output logic [9:0]  p_x,
  output logic [9:0]  p_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             fs_q, fs_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             div_wrap;
  logic             x_wrap;
  logic             y_wrap;

  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    x_wrap   = (x_q == H_LAST);
    y_wrap   = (y_q == V_LAST);

    div_d = div_wrap ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    rgb_d = rgb_q;

    // Counters advance on the same edge that raises p_tick.
    if (div_wrap) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + 1'b1;
      end
      // Colour for the pixel just finished, gated by its own video_on.
      rgb_d = video_q ? graph_rgb : 12'h000;
    end

    // Decoded from next-state counters so syncs have zero skew to p_x/p_y.
    hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
    vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
    video_d = (x_d < H_VIS) && (y_d < V_VIS);
    fs_d    = div_wrap && x_wrap && y_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      div_q   <= div_d;
      tick_q  <= div_wrap;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign p_tick      = tick_q;
  assign p_x         = x_q;
  assign p_y         = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign frame_start = fs_q;
  assign vga_rgb     = rgb_q;

endmodule
